// File: rtl/ysyx_22050243_gpr_wb_sched_if.sv
// Bundle of issue, EXU/LSU writeback and GPR write-port signals around the writeback scheduler.
// The master side drives requests; the slave side (scheduler) returns grants, stall and the write port.
interface ysyx_22050243_gpr_wb_sched_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64
);
  localparam int unsigned NReg = 2 ** ADDR_WIDTH;

  logic                  iss_valid;
  logic                  iss_rd_en;
  logic [ADDR_WIDTH-1:0] iss_rd;
  logic [ADDR_WIDTH-1:0] iss_rs1;
  logic [ADDR_WIDTH-1:0] iss_rs2;
  logic                  iss_stall;

  logic                  exu_valid;
  logic [ADDR_WIDTH-1:0] exu_rd;
  logic [DATA_WIDTH-1:0] exu_data;
  logic                  exu_ready;

  logic                  lsu_valid;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;
  logic                  lsu_ready;

  logic                  gpr_w_en;
  logic [ADDR_WIDTH-1:0] gpr_w_addr;
  logic [DATA_WIDTH-1:0] gpr_w_data;
  logic [NReg-1:0]       busy_vec;

  modport master (
    output iss_valid, iss_rd_en, iss_rd, iss_rs1, iss_rs2,
    output exu_valid, exu_rd, exu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  iss_stall, exu_ready, lsu_ready,
    input  gpr_w_en, gpr_w_addr, gpr_w_data, busy_vec
  );

  modport slave (
    input  iss_valid, iss_rd_en, iss_rd, iss_rs1, iss_rs2,
    input  exu_valid, exu_rd, exu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output iss_stall, exu_ready, lsu_ready,
    output gpr_w_en, gpr_w_addr, gpr_w_data, busy_vec
  );
endinterface

// File: rtl/ysyx_22050243_gpr_wb_sched.sv
// GPR writeback scheduler: round-robin EXU/LSU arbitration onto one registered write port,
// plus a per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module ysyx_22050243_gpr_wb_sched #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64
) (
  input logic                          clk,
  input logic                          rst_n,
  ysyx_22050243_gpr_wb_sched_if.slave  bus
);
  localparam int unsigned NReg = 2 ** ADDR_WIDTH;

  typedef enum logic {SrcExu, SrcLsu} src_e;

  src_e                  rr_last_q, rr_last_d;
  logic [NReg-1:0]       busy_q, busy_d;
  logic                  w_en_q, w_en_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;

  logic                  exu_gnt, lsu_gnt, wb_fire, wb_write, iss_fire;
  logic [ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;

  // Stall looks only at registered busy; a same-cycle clear is covered by GPR forwarding later.
  assign bus.iss_stall = bus.iss_valid &
                         (busy_q[bus.iss_rs1] | busy_q[bus.iss_rs2] |
                          (bus.iss_rd_en & busy_q[bus.iss_rd]));
  assign iss_fire = bus.iss_valid & ~bus.iss_stall & bus.iss_rd_en & (bus.iss_rd != '0);

  // On conflict the source that did not win last time is granted.
  assign exu_gnt = bus.exu_valid & (~bus.lsu_valid | (rr_last_q == SrcLsu));
  assign lsu_gnt = bus.lsu_valid & (~bus.exu_valid | (rr_last_q == SrcExu));
  assign bus.exu_ready = exu_gnt;
  assign bus.lsu_ready = lsu_gnt;

  assign wb_fire  = exu_gnt | lsu_gnt;
  assign wb_rd    = lsu_gnt ? bus.lsu_rd : bus.exu_rd;
  assign wb_data  = lsu_gnt ? bus.lsu_data : bus.exu_data;
  assign wb_write = wb_fire & (wb_rd != '0);

  always_comb begin
    rr_last_d = rr_last_q;
    busy_d    = busy_q;
    w_en_d    = wb_write;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    if (exu_gnt) rr_last_d = SrcExu;
    if (lsu_gnt) rr_last_d = SrcLsu;
    if (wb_write) begin
      busy_d[wb_rd] = 1'b0;
      w_addr_d      = wb_rd;
      w_data_d      = wb_data;
    end
    // Set is applied after clear so a same-cycle issue to the same register wins.
    if (iss_fire) busy_d[bus.iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= SrcExu;
      busy_q    <= '0;
      w_en_q    <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      busy_q    <= busy_d;
      w_en_q    <= w_en_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
    end
  end

  assign bus.gpr_w_en   = w_en_q;
  assign bus.gpr_w_addr = w_addr_q;
  assign bus.gpr_w_data = w_data_q;
  assign bus.busy_vec   = busy_q;
endmodule

// File: tb/tb_ysyx_22050243_gpr_wb_sched.sv
// Directed bench for the GPR writeback scheduler: reset, RAW, conflict round-robin, x0,
// simultaneous set/clear, WAW, and asynchronous reset mid-run.
module tb_ysyx_22050243_gpr_wb_sched;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ysyx_22050243_gpr_wb_sched_if #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) bus ();

  ysyx_22050243_gpr_wb_sched #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid = 1'b0;
    bus.iss_rd_en = 1'b0;
    bus.iss_rd    = '0;
    bus.iss_rs1   = '0;
    bus.iss_rs2   = '0;
    bus.exu_valid = 1'b0;
    bus.exu_rd    = '0;
    bus.exu_data  = '0;
    bus.lsu_valid = 1'b0;
    bus.lsu_rd    = '0;
    bus.lsu_data  = '0;
  endtask

  task automatic issue(input logic rd_en, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2);
    bus.iss_valid = 1'b1;
    bus.iss_rd_en = rd_en;
    bus.iss_rd    = rd;
    bus.iss_rs1   = rs1;
    bus.iss_rs2   = rs2;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle();
    #3;
    chk("rst_busy", 64'(bus.busy_vec), 64'h0);
    chk("rst_wen", 64'(bus.gpr_w_en), 64'h0);
    chk("rst_waddr", 64'(bus.gpr_w_addr), 64'h0);
    chk("rst_wdata", bus.gpr_w_data, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // RAW on x5
    issue(1'b1, 5'd5, 5'd0, 5'd0);
    #1 chk("raw_fire_nostall", 64'(bus.iss_stall), 64'h0);
    tick();
    chk("raw_busy5", 64'(bus.busy_vec), 64'h20);
    issue(1'b0, 5'd0, 5'd5, 5'd0);
    #1 chk("raw_stall", 64'(bus.iss_stall), 64'h1);
    tick();
    chk("raw_stall_hold", 64'(bus.iss_stall), 64'h1);
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd5;
    bus.exu_data  = 64'hDEAD_BEEF;
    #1 chk("raw_exu_ready", 64'(bus.exu_ready), 64'h1);
    chk("raw_stall_on_clear", 64'(bus.iss_stall), 64'h1);
    tick();
    bus.exu_valid = 1'b0;
    chk("raw_wen", 64'(bus.gpr_w_en), 64'h1);
    chk("raw_waddr", 64'(bus.gpr_w_addr), 64'd5);
    chk("raw_wdata", bus.gpr_w_data, 64'hDEAD_BEEF);
    chk("raw_busy_clr", 64'(bus.busy_vec), 64'h0);
    chk("raw_unstall", 64'(bus.iss_stall), 64'h0);
    idle();

    // Conflict: last grant was EXU, so LSU wins first
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd3;
    bus.exu_data  = 64'h11;
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd4;
    bus.lsu_data  = 64'h22;
    #1 chk("cf0_lsu_ready", 64'(bus.lsu_ready), 64'h1);
    chk("cf0_exu_ready", 64'(bus.exu_ready), 64'h0);
    tick();
    bus.lsu_valid = 1'b0;
    chk("cf0_wen", 64'(bus.gpr_w_en), 64'h1);
    chk("cf0_waddr", 64'(bus.gpr_w_addr), 64'd4);
    chk("cf0_wdata", bus.gpr_w_data, 64'h22);
    #1 chk("cf1_exu_ready", 64'(bus.exu_ready), 64'h1);
    chk("cf1_lsu_ready", 64'(bus.lsu_ready), 64'h0);
    tick();
    bus.exu_valid = 1'b0;
    chk("cf1_waddr", 64'(bus.gpr_w_addr), 64'd3);
    chk("cf1_wdata", bus.gpr_w_data, 64'h11);
    tick();
    chk("cf_idle_wen", 64'(bus.gpr_w_en), 64'h0);
    chk("cf_idle_addr_hold", 64'(bus.gpr_w_addr), 64'd3);
    chk("cf_idle_data_hold", bus.gpr_w_data, 64'h11);

    // x0 writeback alongside an issue to x10
    issue(1'b1, 5'd10, 5'd0, 5'd0);
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd0;
    bus.lsu_data  = 64'hFF;
    #1 chk("x0_lsu_ready", 64'(bus.lsu_ready), 64'h1);
    tick();
    idle();
    chk("x0_wen", 64'(bus.gpr_w_en), 64'h0);
    chk("x0_busy", 64'(bus.busy_vec), 64'h400);
    chk("x0_data_hold", bus.gpr_w_data, 64'h11);

    // WAW on x9
    issue(1'b1, 5'd9, 5'd0, 5'd0);
    tick();
    chk("waw_busy", 64'(bus.busy_vec), 64'h600);
    #1 chk("waw_stall", 64'(bus.iss_stall), 64'h1);
    bus.iss_rd_en = 1'b0;
    #1 chk("waw_nord_nostall", 64'(bus.iss_stall), 64'h0);
    tick();
    chk("waw_busy_hold", 64'(bus.busy_vec), 64'h600);
    idle();

    // Same-cycle issue fire and EXU writeback to x7: set wins
    issue(1'b1, 5'd7, 5'd0, 5'd0);
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd7;
    bus.exu_data  = 64'h77;
    #1 chk("sim_exu_ready", 64'(bus.exu_ready), 64'h1);
    tick();
    idle();
    chk("sim_wen", 64'(bus.gpr_w_en), 64'h1);
    chk("sim_waddr", 64'(bus.gpr_w_addr), 64'd7);
    chk("sim_wdata", bus.gpr_w_data, 64'h77);
    chk("sim_busy", 64'(bus.busy_vec), 64'h680);

    // Retire x7 and x9, leaving only x10 busy
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd7;
    bus.exu_data  = 64'h7;
    tick();
    idle();
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd9;
    bus.lsu_data  = 64'h9;
    tick();
    idle();
    chk("pre_rst_busy", 64'(bus.busy_vec), 64'h400);
    chk("pre_rst_wen", 64'(bus.gpr_w_en), 64'h1);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1 chk("arst_busy", 64'(bus.busy_vec), 64'h0);
    chk("arst_wen", 64'(bus.gpr_w_en), 64'h0);
    chk("arst_waddr", 64'(bus.gpr_w_addr), 64'h0);
    chk("arst_wdata", bus.gpr_w_data, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Round-robin state was reset to EXU, so LSU wins despite LSU being last before reset
    bus.exu_valid = 1'b1;
    bus.exu_rd    = 5'd1;
    bus.exu_data  = 64'hA1;
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd2;
    bus.lsu_data  = 64'hB2;
    #1 chk("post_rst_lsu_ready", 64'(bus.lsu_ready), 64'h1);
    chk("post_rst_exu_ready", 64'(bus.exu_ready), 64'h0);
    tick();
    idle();
    chk("post_rst_waddr", 64'(bus.gpr_w_addr), 64'd2);
    chk("post_rst_wdata", bus.gpr_w_data, 64'hB2);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
